// File: rtl/bank_rr_arbiter.sv
// Round-robin arbiter: merges NUM_CH bank request queues into one registered, backpressured stream.
// Define BANK_ARB_BURST_EN to keep the grant on one bank for up to MAX_BURST back-to-back captures.
module bank_rr_arbiter #(
    parameter int NUM_CH    = 16,
    parameter int REQ_SIZE  = 32,
    parameter int MAX_BURST = 4,
    localparam int ID_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          Req,
    input  logic [NUM_CH*REQ_SIZE-1:0] Data_in,
    output logic [NUM_CH-1:0]          Ack,
    output logic [REQ_SIZE-1:0]        Data_out,
    output logic                       Out_valid,
    input  logic                       Out_ready,
    output logic [ID_W-1:0]            Grant_id
);

    if (NUM_CH < 2 || REQ_SIZE < 1 || MAX_BURST < 1) begin : g_param_check
        $error("bank_rr_arbiter: illegal parameter combination");
    end

    logic [REQ_SIZE-1:0] ch_data [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign ch_data[g] = Data_in[g*REQ_SIZE +: REQ_SIZE];
    end

    logic                out_valid_q, out_valid_d;
    logic [REQ_SIZE-1:0] data_out_q,  data_out_d;
    logic [ID_W-1:0]     grant_id_q,  grant_id_d;
    logic [ID_W-1:0]     ptr_q,       ptr_d;

    logic                space;
    logic                sel_found;
    logic [ID_W-1:0]     sel_idx;
    logic [ID_W-1:0]     cand;
    int                  cand_int;
    logic                capture;

`ifdef BANK_ARB_BURST_EN
    localparam int BC_W = $clog2(MAX_BURST + 1);

    logic [ID_W-1:0] last_g_q,    last_g_d;
    logic [BC_W-1:0] burst_cnt_q, burst_cnt_d;
`endif

    // Out_ready feeds Ack combinationally: a taken word frees the register in the same
    // cycle, giving one word per cycle. Data_out itself only ever comes from a flop.
    always_comb begin
        space     = !out_valid_q || Out_ready;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        cand_int  = 0;

`ifdef BANK_ARB_BURST_EN
        if (Req[last_g_q] && (burst_cnt_q < BC_W'(MAX_BURST))) begin
            sel_found = 1'b1;
            sel_idx   = last_g_q;
        end
`endif

        for (int k = 0; k < NUM_CH; k++) begin
            cand_int = int'(ptr_q) + k;
            if (cand_int >= NUM_CH) begin
                cand_int = cand_int - NUM_CH;
            end
            cand = ID_W'(cand_int);
            if (!sel_found && Req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end

        capture = rst_n && space && sel_found;

        Ack = '0;
        if (capture) begin
            Ack[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        grant_id_d  = grant_id_q;
        ptr_d       = ptr_q;

        if (capture) begin
            out_valid_d = 1'b1;
            data_out_d  = ch_data[sel_idx];
            grant_id_d  = sel_idx;
            ptr_d       = (sel_idx == ID_W'(NUM_CH - 1)) ? '0 : sel_idx + ID_W'(1);
        end else if (Out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef BANK_ARB_BURST_EN
    // A repeat grant reached through the plain search once the burst is exhausted
    // (lone requester) starts a fresh burst rather than overflowing the count.
    always_comb begin
        last_g_d    = last_g_q;
        burst_cnt_d = burst_cnt_q;

        if (capture) begin
            last_g_d = sel_idx;
            if ((sel_idx == last_g_q) && (burst_cnt_q < BC_W'(MAX_BURST))) begin
                burst_cnt_d = burst_cnt_q + BC_W'(1);
            end else begin
                burst_cnt_d = BC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_g_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            last_g_q    <= last_g_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            grant_id_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            grant_id_q  <= grant_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign Out_valid = out_valid_q;
    assign Data_out  = data_out_q;
    assign Grant_id  = grant_id_q;

endmodule

// File: tb/tb_bank_rr_arbiter.sv
// Directed bench for bank_rr_arbiter: a 16-channel instance driven from a vector table
// and a 5-channel instance for wrap-around and single-requester sequences.
module tb_bank_rr_arbiter;

    localparam int NCH = 16;
    localparam int W   = 32;

    typedef struct {
        logic            rst_n;
        logic [NCH-1:0]  req;
        logic            rdy;
        logic [NCH-1:0]  exp_ack;
        logic            exp_valid;
        logic [3:0]      exp_gid;
        logic [W-1:0]    exp_data;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [NCH-1:0]     req;
    logic [NCH*W-1:0]   data_in;
    logic [NCH-1:0]     ack;
    logic [W-1:0]       data_out;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         grant_id;

    logic [4:0]         req5;
    logic [5*W-1:0]     data5;
    logic [4:0]         ack5;
    logic [W-1:0]       dout5;
    logic               v5;
    logic               rdy5;
    logic [2:0]         gid5;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs[$];

    bank_rr_arbiter #(.NUM_CH(NCH), .REQ_SIZE(W), .MAX_BURST(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Req       (req),
        .Data_in   (data_in),
        .Ack       (ack),
        .Data_out  (data_out),
        .Out_valid (out_valid),
        .Out_ready (out_ready),
        .Grant_id  (grant_id)
    );

    bank_rr_arbiter #(.NUM_CH(5), .REQ_SIZE(W), .MAX_BURST(4)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .Req       (req5),
        .Data_in   (data5),
        .Ack       (ack5),
        .Data_out  (dout5),
        .Out_valid (v5),
        .Out_ready (rdy5),
        .Grant_id  (gid5)
    );

    function automatic logic [W-1:0] chd(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    function automatic vec_t mk(input logic r, input logic [NCH-1:0] rq, input logic rdy,
                                input logic [NCH-1:0] ea, input logic ev,
                                input logic [3:0] eg, input logic [W-1:0] ed);
        vec_t v;
        v.rst_n = r;  v.req = rq;  v.rdy = rdy;
        v.exp_ack = ea;  v.exp_valid = ev;  v.exp_gid = eg;  v.exp_data = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle: Ack is checked before the edge, registered outputs just after it.
    task automatic step16(input vec_t v, input string tag);
        rst_n     = v.rst_n;
        req       = v.req;
        out_ready = v.rdy;
        #1;
        check({tag, " ack"}, 32'(ack), 32'(v.exp_ack));
        @(posedge clk);
        #1;
        check({tag, " valid"}, 32'(out_valid), 32'(v.exp_valid));
        check({tag, " gid"},   32'(grant_id),  32'(v.exp_gid));
        check({tag, " data"},  data_out,       v.exp_data);
    endtask

    task automatic step5(input logic [4:0] r, input logic [2:0] eg, input string tag);
        logic [4:0] ea;
        ea   = 5'b00001 << eg;
        req5 = r;
        rdy5 = 1'b1;
        #1;
        check({tag, " ack5"}, 32'(ack5), 32'(ea));
        @(posedge clk);
        #1;
        check({tag, " valid5"}, 32'(v5),   32'd1);
        check({tag, " gid5"},   32'(gid5), 32'(eg));
        check({tag, " data5"},  dout5,     chd(int'(eg)));
    endtask

    initial begin
        int g;
        rst_n     = 1'b0;
        req       = '0;
        out_ready = 1'b1;
        req5      = '0;
        rdy5      = 1'b1;
        for (int i = 0; i < NCH; i++) data_in[i*W +: W] = chd(i);
        for (int i = 0; i < 5; i++)   data5[i*W +: W]   = chd(i);

        // Reset held with every channel requesting, then release: first capture is ch0.
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 16'hFFFF, 1'b1, '0, 1'b0, 4'd0, '0));
        for (int k = 0; k < 17; k++) begin
`ifdef BANK_ARB_BURST_EN
            g = (k / 4) % NCH;
`else
            g = k % NCH;
`endif
            vecs.push_back(mk(1'b1, 16'hFFFF, 1'b1, 16'(1 << g), 1'b1, 4'(g), chd(g)));
        end
        for (int i = 0; i < vecs.size(); i++) step16(vecs[i], $sformatf("vec%0d", i));

        // Reset mid-operation discards a held word and returns ptr to 0.
        data_in[3*W +: W] = 32'hA5A5_A5A5;
        step16(mk(1'b1, 16'h0008, 1'b1, 16'h0008, 1'b1, 4'd3, 32'hA5A5_A5A5), "midrst_cap");
        step16(mk(1'b1, 16'h0000, 1'b0, 16'h0000, 1'b1, 4'd3, 32'hA5A5_A5A5), "midrst_hold");
        step16(mk(1'b0, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 4'd0, 32'h0),         "midrst_rst");
        data_in[3*W +: W] = chd(3);

        // Backpressure: ch0 captured, held 5 cycles, ch4 taken on the edge ch0 leaves.
        step16(mk(1'b1, 16'h0011, 1'b0, 16'h0001, 1'b1, 4'd0, chd(0)), "bp_cap0");
        for (int i = 0; i < 5; i++)
            step16(mk(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 4'd0, chd(0)), $sformatf("bp_hold%0d", i));
        step16(mk(1'b1, 16'h0010, 1'b1, 16'h0010, 1'b1, 4'd4, chd(4)), "bp_cap4");
        step16(mk(1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd4, chd(4)), "bp_drain");

        // Two requesters, channel 0 dropping out after two grants.
`ifdef BANK_ARB_BURST_EN
        step16(mk(1'b1, 16'h0003, 1'b1, 16'h0001, 1'b1, 4'd0, chd(0)), "drop_a");
        step16(mk(1'b1, 16'h0003, 1'b1, 16'h0001, 1'b1, 4'd0, chd(0)), "drop_b");
`else
        step16(mk(1'b1, 16'h0003, 1'b1, 16'h0001, 1'b1, 4'd0, chd(0)), "drop_a");
        step16(mk(1'b1, 16'h0003, 1'b1, 16'h0002, 1'b1, 4'd1, chd(1)), "drop_b");
`endif
        step16(mk(1'b1, 16'h0002, 1'b1, 16'h0002, 1'b1, 4'd1, chd(1)), "drop_c");
        step16(mk(1'b1, 16'h0002, 1'b1, 16'h0002, 1'b1, 4'd1, chd(1)), "drop_d");

        // Five-channel instance: wrap from ch4 back to ch0, then a lone requester.
        req       = '0;
        out_ready = 1'b1;
        step5(5'b10000, 3'd4, "w5_first");
`ifdef BANK_ARB_BURST_EN
        step5(5'b10001, 3'd4, "w5_a");
        step5(5'b10001, 3'd4, "w5_b");
        step5(5'b10001, 3'd4, "w5_c");
        step5(5'b10001, 3'd0, "w5_d");
`else
        step5(5'b10001, 3'd0, "w5_a");
        step5(5'b10001, 3'd4, "w5_b");
        step5(5'b10001, 3'd0, "w5_c");
        step5(5'b10001, 3'd4, "w5_d");
`endif
        for (int i = 0; i < 6; i++) step5(5'b00100, 3'd2, $sformatf("single%0d", i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bank_rr_arbiter.md
# bank_rr_arbiter

Parametrised round-robin arbiter that merges NUM_CH per-bank request queues into one registered request stream toward the command scheduler. Each cycle at most one channel is acknowledged and its request word captured into a single output register with valid/ready backpressure. Optional burst holding keeps the grant on one bank for up to MAX_BURST back-to-back transfers to preserve row locality.

## Interface
- NUM_CH, 16: number of request channels (banks); ≥2
- REQ_SIZE, 32: request word width in bits; ≥1
- MAX_BURST, 4: max consecutive grants to one channel when burst holding is compiled in; ≥1
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset; synchronous and active-low
- Req  in  NUM_CH  per-channel request pending; Data_in[i] must be valid whenever Req[i]=1
- Data_in  in  NUM_CH×REQ_SIZE  packed per-channel request words
- Ack  out  NUM_CH  one-hot (or zero) capture strobe; Ack[i]=1 means Data_in[i] is taken at this edge
- Data_out  out  REQ_SIZE  registered granted request word
- Out_valid  out  1  Data_out holds an untaken request
- Out_ready  in  1  downstream accepts Data_out this cycle
- Grant_id  out  max(1,$clog2(NUM_CH))  channel index of the word in Data_out

## Operation
- Output space: space = !Out_valid || Out_ready.
- Ack is combinational from Req, pointer state and space; Ack=0 when space=0 or Req=0.
- Selection: search channels starting at ptr, ascending, wrapping NUM_CH-1→0; first set Req wins.
- On capture of channel g: Data_out←Data_in[g], Grant_id←g, Out_valid←1, ptr←(g+1) mod NUM_CH.
- Out_valid cleared when Out_ready=1 and no capture in the same cycle; capture with Out_ready=1 replaces the word (full throughput, 1 word/cycle).
- No capture and Out_ready=0: Data_out, Grant_id, Out_valid hold.
- Single requester: granted every cycle it requests (search wraps back to it).
- Burst (when enabled): state last_g, burst_cnt (width $clog2(MAX_BURST+1)). If Req[last_g]=1 and burst_cnt<MAX_BURST, grant last_g ahead of round-robin search; burst_cnt increments on each grant to the same channel, set to 1 on a grant to a new channel. When burst_cnt=MAX_BURST the search starts at last_g+1. burst_cnt unchanged on cycles without capture.
- Reset (synchronous, rst_n=0 at edge): Out_valid=0, Data_out=0, Grant_id=0, ptr=0, last_g=0, burst_cnt=0; Ack forced 0 while rst_n=0. Reset mid-stream discards the held word; no Ack is issued during the reset cycle.

## Timing
- Ack[g] and capture at edge N; Data_out/Out_valid/Grant_id valid after edge N (latency 1).
- Downstream transfer occurs at edge where Out_valid=1 and Out_ready=1.
- Ack never asserted for a channel with Req=0; at most one Ack bit per cycle.
- Requester must hold Req and Data_in stable until it sees Ack; deassert Req the cycle after Ack if nothing further pending.
- No combinational path from Out_ready to Data_out; Out_ready→Ack is combinational (documented).

## Configuration
- BANK_ARB_BURST_EN defined: burst holding as above, up to MAX_BURST consecutive grants to one requesting channel.
- Not defined: pure round-robin; every capture advances ptr past the winner, burst_cnt/last_g logic absent, MAX_BURST ignored.

## Test plan
- Reset: rst_n=0 with Req=16'hFFFF, Out_ready=1 → Ack=0, Out_valid=0, Data_out=0, Grant_id=0 throughout; first edge after release grants ch0.
- Round robin (burst off): Req=16'hFFFF held, Data_in[i]=i, Out_ready=1 → Grant_id 0,1,…,15,0 on consecutive cycles, one Ack bit per cycle.
- Backpressure: Req=16'h0011, Out_ready=0 → ch0 captured, then Ack=0 and Data_out=0 held for 5 cycles; Out_ready=1 → ch4 captured same edge ch0 leaves.
- Burst (BANK_ARB_BURST_EN, MAX_BURST=4): Req=16'h0003 held → Grant_id 0,0,0,0,1,1,1,1,0…; drop Req[0] after 2 grants → switches to ch1 next cycle.
- Wrap/sparse: NUM_CH=5, Req=5'b10001, after grant to ch4 → next grant ch0; single requester Req=5'b00100 → ch2 granted every cycle.
- Reset mid-operation: Out_valid=1 with Data_out=32'hA5A5_A5A5, Out_ready=0, pulse rst_n=0 one cycle → Out_valid=0, Data_out=0, ptr=0 next edge.
